// File: rtl/qnet_pkg.sv
// Shared types and constants for the QuaNet frame timer.
// FSM state enum, minimum frame period, default trigger length.
package qnet_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int QNET_MIN_FRAME_PD = 2;
  localparam int QNET_TRIG_LEN     = 8;

endpackage

// File: rtl/qnet_frame_timer_sync_edge.sv
// qnet_sync_edge: 2-FF synchronizer plus rising-edge pulse.
// Ports: clk, resetn, din (async), pulse (1-cycle, clk domain).
module qnet_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic pulse
);

  logic [2:0] sr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sr <= '0;
    else         sr <= {sr[1:0], din};
  end

  assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/qnet_frame_timer.sv
// qnet_frame_timer: per-frame scope trigger and RX switch gate.
// Ports: clk, resetn, go, abort, frame_pd, num_frames, sw_dly,
//   sw_len, sw_inv, [ext_trig if QNET_FRAME_TIMER_EXT_SYNC_EN],
//   dac_xfer_out, rxq_sw_ctl, busy, frm_cnt, done, ovf.
module qnet_frame_timer
  import qnet_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int NFRM_W   = 10,
  parameter int TRIG_LEN = QNET_TRIG_LEN
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              abort,
  input  logic [CNT_W-1:0]  frame_pd,
  input  logic [NFRM_W-1:0] num_frames,
  input  logic [CNT_W-1:0]  sw_dly,
  input  logic [CNT_W-1:0]  sw_len,
  input  logic              sw_inv,
`ifdef QNET_FRAME_TIMER_EXT_SYNC_EN
  input  logic              ext_trig,
`endif
  output logic              dac_xfer_out,
  output logic              rxq_sw_ctl,
  output logic              busy,
  output logic [NFRM_W-1:0] frm_cnt,
  output logic              done,
  output logic              ovf
);

  localparam logic [CNT_W-1:0] MIN_PD =
    CNT_W'(QNET_MIN_FRAME_PD);
  localparam logic [CNT_W-1:0] TLEN = CNT_W'(TRIG_LEN);

  logic go_any;

`ifdef QNET_FRAME_TIMER_EXT_SYNC_EN
  logic ext_pulse;

  qnet_sync_edge u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (ext_trig),
    .pulse  (ext_pulse)
  );

  assign go_any = go | ext_pulse;
`else
  assign go_any = go;
`endif

  state_t state, state_n;

  logic [CNT_W-1:0]  pc, pc_n;
  logic [CNT_W-1:0]  pd_q, pd_n;
  logic [CNT_W-1:0]  dly_q, dly_n;
  logic [CNT_W-1:0]  len_q, len_n;
  logic [NFRM_W-1:0] nf_q, nf_n;
  logic [NFRM_W-1:0] frm_n;
  logic              inv_q, inv_n;
  logic              last;
  logic              done_n, ovf_n;
  logic              run_n, dac_n, sw_on, sw_n;
  logic [CNT_W:0]    win_end;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    frm_n   = frm_cnt;
    pd_n    = pd_q;
    dly_n   = dly_q;
    len_n   = len_q;
    nf_n    = nf_q;
    inv_n   = inv_q;
    done_n  = 1'b0;
    ovf_n   = 1'b0;
    last    = (pc == pd_q - 1'b1);
    unique case (state)
      ST_IDLE: begin
        if (go_any && !abort) begin
          state_n = ST_RUN;
          pc_n    = '0;
          frm_n   = '0;
          pd_n    = (frame_pd < MIN_PD) ? MIN_PD : frame_pd;
          dly_n   = sw_dly;
          len_n   = sw_len;
          nf_n    = num_frames;
          inv_n   = sw_inv;
        end
      end
      ST_RUN: begin
        ovf_n = go_any;
        pc_n  = last ? '0 : pc + 1'b1;
        if (last && frm_cnt != '1)
          frm_n = frm_cnt + 1'b1;
        if (abort)
          state_n = ST_IDLE;
        else if (last && nf_q != '0 && frm_n == nf_q) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-cycle values so that the
  // registered strobes line up with the phase they describe.
  // pc < P always holds, so both windows are clipped at P.
  always_comb begin
    run_n   = (state_n == ST_RUN);
    win_end = {1'b0, dly_n} + {1'b0, len_n};
    dac_n   = run_n && (pc_n < TLEN);
    sw_on   = run_n && (pc_n >= dly_n)
              && ({1'b0, pc_n} < win_end);
    sw_n    = sw_on ^ inv_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      pc           <= '0;
      pd_q         <= MIN_PD;
      dly_q        <= '0;
      len_q        <= '0;
      nf_q         <= '0;
      inv_q        <= 1'b0;
      frm_cnt      <= '0;
      busy         <= 1'b0;
      dac_xfer_out <= 1'b0;
      rxq_sw_ctl   <= 1'b0;
      done         <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pd_q         <= pd_n;
      dly_q        <= dly_n;
      len_q        <= len_n;
      nf_q         <= nf_n;
      inv_q        <= inv_n;
      frm_cnt      <= frm_n;
      busy         <= run_n;
      dac_xfer_out <= dac_n;
      rxq_sw_ctl   <= sw_n;
      done         <= done_n;
      ovf          <= ovf_n;
    end
  end

endmodule
